// File: rtl/free_list_if.sv
// Rename/retire <-> free list bundle: 4-wide allocation, 4-wide release, recovery and status.
interface free_list_if;
  localparam int unsigned LANES = 4;
  localparam int unsigned TAG_W = 7;
  localparam int unsigned CNT_W = 8;

  logic [LANES-1:0]            inst_alloc;
  logic [LANES-1:0][TAG_W-1:0] inst_prd;
  logic                        alloc_stall;
  logic [LANES-1:0]            ret_we;
  logic [LANES-1:0][TAG_W-1:0] ret_prd_old;
  logic                        arch_rat_rec;
  logic [CNT_W-1:0]            free_cnt;
  logic                        fl_err;

  modport master (
    output inst_alloc, ret_we, ret_prd_old, arch_rat_rec,
    input  inst_prd, alloc_stall, free_cnt, fl_err
  );

  modport slave (
    input  inst_alloc, ret_we, ret_prd_old, arch_rat_rec,
    output inst_prd, alloc_stall, free_cnt, fl_err
  );
endinterface

// File: rtl/free_list.sv
// Physical register free list: 128-entry circular tag FIFO, 4 allocs + 4 releases per cycle.
// Optional release checking (sticky fl_err) is built only when FREE_LIST_CHECK_EN is defined.
module free_list (
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave fl
);
  localparam int unsigned LANES     = 4;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned IDX_W     = 7;
  localparam int unsigned PTR_W     = 8;
  localparam int unsigned TAG_W     = 7;
  localparam int unsigned NUM_W     = 3;
  localparam int unsigned ARCH_TAGS = 32;
  localparam int unsigned INIT_FREE = 96;

  logic [DEPTH-1:0][TAG_W-1:0] mem;
  logic [PTR_W-1:0]            head;
  logic [PTR_W-1:0]            commit_head;
  logic [PTR_W-1:0]            tail;
  logic [PTR_W-1:0]            free_cnt;
  logic [NUM_W-1:0]            req_num;
  logic [NUM_W-1:0]            rel_num;
  logic [LANES-1:0][IDX_W-1:0] rd_idx;
  logic [LANES-1:0][IDX_W-1:0] wr_idx;
  logic                        stall;

  // Read slot per lane: head plus the number of lower lanes also requesting.
  always_comb begin : alloc_offsets
    logic [NUM_W-1:0] acc;
    acc    = '0;
    rd_idx = '0;
    for (int n = 0; n < LANES; n++) begin
      rd_idx[n] = head[IDX_W-1:0] + IDX_W'(acc);
      acc       = acc + NUM_W'(fl.inst_alloc[n]);
    end
    req_num = acc;
  end

  // Write slot per lane: tail plus the number of lower lanes also releasing.
  always_comb begin : release_offsets
    logic [NUM_W-1:0] acc;
    acc    = '0;
    wr_idx = '0;
    for (int n = 0; n < LANES; n++) begin
      wr_idx[n] = tail[IDX_W-1:0] + IDX_W'(acc);
      acc       = acc + NUM_W'(fl.ret_we[n]);
    end
    rel_num = acc;
  end

  // Count depends only on pointer state; releases this cycle are not yet visible.
  assign free_cnt       = tail - head;
  assign stall          = PTR_W'(req_num) > free_cnt;
  assign fl.free_cnt    = free_cnt;
  assign fl.alloc_stall = stall;

  always_comb begin
    fl.inst_prd = '0;
    for (int n = 0; n < LANES; n++)
      fl.inst_prd[n] = mem[rd_idx[n]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= PTR_W'(INIT_FREE);
    end else begin
      tail        <= tail + PTR_W'(rel_num);
      commit_head <= commit_head + PTR_W'(rel_num);
      if (fl.arch_rat_rec)
        head <= commit_head + PTR_W'(rel_num);
      else if (!stall)
        head <= head + PTR_W'(req_num);
    end
  end

  // One register per entry; at most one release lane targets a given slot per cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    localparam logic [TAG_W-1:0] INIT = (i < INIT_FREE) ? TAG_W'(ARCH_TAGS + i) : '0;
    logic             hit;
    logic [TAG_W-1:0] wdata;
    logic [TAG_W-1:0] q;

    always_comb begin
      hit   = 1'b0;
      wdata = '0;
      for (int n = 0; n < LANES; n++) begin
        if (fl.ret_we[n] && (wr_idx[n] == IDX_W'(i))) begin
          hit   = 1'b1;
          wdata = fl.ret_prd_old[n];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset)
        q <= INIT;
      else if (hit)
        q <= wdata;
    end

    assign mem[i] = q;
  end

`ifdef FREE_LIST_CHECK_EN
  localparam int unsigned CHK_W = PTR_W + 1;

  logic             err;
  logic             bad_tag;
  logic             overflow;

  // Flag releases of architectural tags or releases that would overfill the list.
  always_comb begin
    bad_tag = 1'b0;
    for (int n = 0; n < LANES; n++)
      if (fl.ret_we[n] && (fl.ret_prd_old[n] < TAG_W'(ARCH_TAGS)))
        bad_tag = 1'b1;
  end

  assign overflow = (CHK_W'(free_cnt) + CHK_W'(rel_num)) > CHK_W'(DEPTH);

  always_ff @(posedge clock) begin
    if (reset)
      err <= 1'b0;
    else if (bad_tag || overflow)
      err <= 1'b1;
  end

  assign fl.fl_err = err;
`else
  assign fl.fl_err = 1'b0;
`endif

endmodule
